// File: rtl/io_bus_ctrl.sv
// rtl/io_bus_ctrl.sv - memory-mapped I/O unit: key/switch debounce, sticky key status, HEX/LED registers
module io_bus_ctrl #(
    parameter int DBITS      = 16,
    parameter int DEB_CYCLES = 500000,
    parameter int CNTBITS    = 20
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DBITS-1:0] ADDR,
    input  logic [DBITS-1:0] DIN,
    input  logic             WE,
    output logic [DBITS-1:0] DOUT,
    output logic             SEL,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [15:0]      HEX_VAL,
    output logic [9:0]       LEDR_VAL,
    output logic [7:0]       LEDG_VAL
);

    localparam int NIN = 14;
    localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEB_CYCLES - 1);
    localparam logic [15:0] DEAD = 16'hDEAD;

    localparam logic [2:0] IDX_KDATA = 3'd0;
    localparam logic [2:0] IDX_SDATA = 3'd1;
    localparam logic [2:0] IDX_KSTAT = 3'd2;
    localparam logic [2:0] IDX_HEX   = 3'd4;
    localparam logic [2:0] IDX_LEDR  = 3'd5;
    localparam logic [2:0] IDX_LEDG  = 3'd6;

    logic [3:0]         key_s1, key_s2;
    logic [9:0]         sw_s1, sw_s2;
    logic [NIN-1:0]     sync_vec;
    logic [NIN-1:0]     stable;
    logic [NIN-1:0]     hit;
    logic [CNTBITS-1:0] cnt [NIN];
    logic [3:0]         press;
    logic [3:0]         kstat;
    logic [3:0]         kclr;
    logic [15:0]        hex_q;
    logic [9:0]         ledr_q;
    logic [7:0]         ledg_q;
    logic [2:0]         idx;
    logic               wr_en;
    logic [15:0]        rdata;
    logic               addr_unused;

    // Keys sync to 1 (released) so reset never looks like a press.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw_s1  <= 10'd0;
            sw_s2  <= 10'd0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    // Keys are debounced in pressed (inverted) form; bits [3:0] keys, [13:4] switches.
    assign sync_vec = {sw_s2, ~key_s2};

    always_comb begin
        hit = '0;
        for (int i = 0; i < NIN; i++) begin
            hit[i] = (sync_vec[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stable <= '0;
            for (int i = 0; i < NIN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (sync_vec[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (hit[i]) begin
                    stable[i] <= sync_vec[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNTBITS'(1);
                end
            end
        end
    end

    assign press = hit[3:0] & sync_vec[3:0];

    assign SEL         = (ADDR[15:4] == 12'hFFF);
    assign idx         = ADDR[3:1];
    assign wr_en       = WE && SEL;
    assign addr_unused = ADDR[0];

    assign kclr = (wr_en && idx == IDX_KSTAT) ? DIN[3:0] : 4'd0;

    // A press landing on the same edge as a W1C keeps the bit set.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            kstat  <= 4'd0;
            hex_q  <= 16'd0;
            ledr_q <= 10'd0;
            ledg_q <= 8'd0;
        end else begin
            kstat <= (kstat & ~kclr) | press;
            if (wr_en && idx == IDX_HEX)  hex_q  <= DIN[15:0];
            if (wr_en && idx == IDX_LEDR) ledr_q <= DIN[9:0];
            if (wr_en && idx == IDX_LEDG) ledg_q <= DIN[7:0];
        end
    end

    always_comb begin
        rdata = DEAD;
        if (SEL) begin
            case (idx)
                IDX_KDATA: rdata = {12'd0, stable[3:0]};
                IDX_SDATA: rdata = {6'd0, stable[13:4]};
                IDX_KSTAT: rdata = {12'd0, kstat};
                IDX_HEX:   rdata = hex_q;
                IDX_LEDR:  rdata = {6'd0, ledr_q};
                IDX_LEDG:  rdata = {8'd0, ledg_q};
                default:   rdata = DEAD;
            endcase
        end
    end

    assign DOUT     = DBITS'(rdata);
    assign HEX_VAL  = hex_q;
    assign LEDR_VAL = ledr_q;
    assign LEDG_VAL = ledg_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb/tb_io_bus_ctrl.sv - self-checking bench for io_bus_ctrl with a windowed debounce reference model
module tb_io_bus_ctrl;

    localparam int DEB = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] ADDR, DIN;
    logic        WE;
    logic [15:0] DOUT;
    logic        SEL;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [15:0] HEX_VAL;
    logic [9:0]  LEDR_VAL;
    logic [7:0]  LEDG_VAL;

    io_bus_ctrl #(.DBITS(16), .DEB_CYCLES(DEB), .CNTBITS(3)) dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN), .WE(WE),
        .DOUT(DOUT), .SEL(SEL), .KEY(KEY), .SW(SW),
        .HEX_VAL(HEX_VAL), .LEDR_VAL(LEDR_VAL), .LEDG_VAL(LEDG_VAL)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [3:0]  m_kstat;
    logic [13:0] m_stable, m_s1, m_s2;
    logic [13:0] hist [DEB];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] m_dout(input logic [15:0] a);
        if (a[15:4] != 12'hFFF) return 16'hDEAD;
        case (a[3:1])
            3'd0:    return {12'd0, m_stable[3:0]};
            3'd1:    return {6'd0, m_stable[13:4]};
            3'd2:    return {12'd0, m_kstat};
            3'd4:    return m_hex;
            3'd5:    return {6'd0, m_ledr};
            3'd6:    return {8'd0, m_ledg};
            default: return 16'hDEAD;
        endcase
    endfunction

    // Debounced value flips once the last DEB synchronised samples all disagree with it.
    task automatic model_edge();
        logic [13:0] nstable;
        logic [3:0]  set, clr;
        bit          all;
        if (RESET) begin
            m_hex = 0; m_ledr = 0; m_ledg = 0; m_kstat = 0;
            m_stable = 0; m_s1 = 0; m_s2 = 0;
            for (int i = 0; i < DEB; i++) hist[i] = 0;
        end else begin
            for (int i = DEB - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = m_s2;
            nstable = m_stable;
            set = 0;
            for (int b = 0; b < 14; b++) begin
                all = 1;
                for (int i = 0; i < DEB; i++) if (hist[i][b] == m_stable[b]) all = 0;
                if (all) begin
                    nstable[b] = ~m_stable[b];
                    if (b < 4 && nstable[b]) set[b] = 1'b1;
                end
            end
            clr = 0;
            if (WE && ADDR[15:4] == 12'hFFF) begin
                case (ADDR[3:1])
                    3'd2: clr = DIN[3:0];
                    3'd4: m_hex = DIN;
                    3'd5: m_ledr = DIN[9:0];
                    3'd6: m_ledg = DIN[7:0];
                    default: ;
                endcase
            end
            m_kstat  = (m_kstat & ~clr) | set;
            m_stable = nstable;
            m_s2     = m_s1;
            m_s1     = {SW, ~KEY};
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check("hex_val", HEX_VAL, m_hex);
        check("ledr_val", {6'd0, LEDR_VAL}, {6'd0, m_ledr});
        check("ledg_val", {8'd0, LEDG_VAL}, {8'd0, m_ledg});
        check("sel", {15'd0, SEL}, {15'd0, (ADDR[15:4] == 12'hFFF)});
        check("dout", DOUT, m_dout(ADDR));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
        WE = 1'b0;
        ADDR = a;
        #1;
        check(tag, DOUT, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a; DIN = d; WE = 1'b1;
        step();
        WE = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; ADDR = 16'h0; DIN = 16'h0; WE = 1'b0; KEY = 4'hF; SW = 10'h0;
        m_hex = 0; m_ledr = 0; m_ledg = 0; m_kstat = 0; m_stable = 0; m_s1 = 0; m_s2 = 0;
        for (int i = 0; i < DEB; i++) hist[i] = 0;
        step();
        RESET = 1'b0;

        rd(16'hFFF8, 16'h0000, "rst_hex");
        rd(16'hFFFA, 16'h0000, "rst_ledr");
        rd(16'hFFFC, 16'h0000, "rst_ledg");
        step();
        rd(16'hFFF4, 16'h0000, "rst_kstat");
        rd(16'hFFF6, 16'hDEAD, "hole_dead");
        rd(16'h0100, 16'hDEAD, "out_dead");
        check("out_sel", {15'd0, SEL}, 16'd0);

        wr(16'hFFF8, 16'hBEEF);
        check("hex_after_wr", HEX_VAL, 16'hBEEF);
        wr(16'hFFFA, 16'h03FF);
        check("ledr_after_wr", {6'd0, LEDR_VAL}, 16'h03FF);
        wr(16'hFFFC, 16'hFFFF);
        check("ledg_after_wr", {8'd0, LEDG_VAL}, 16'h00FF);
        rd(16'hFFF8, 16'hBEEF, "rb_hex");
        rd(16'hFFFB, 16'h03FF, "rb_ledr_odd");
        rd(16'hFFFC, 16'h00FF, "rb_ledg");

        KEY = 4'b1011;
        for (int k = 1; k <= 6; k++) begin
            step();
            rd(16'hFFF0, (k == 6) ? 16'h0004 : 16'h0000, "kdata_press");
            rd(16'hFFF4, (k == 6) ? 16'h0004 : 16'h0000, "kstat_press");
        end
        KEY = 4'hF;
        steps(6);
        rd(16'hFFF0, 16'h0000, "kdata_release");
        rd(16'hFFF4, 16'h0004, "kstat_sticky");

        SW = 10'h020;
        steps(3);
        SW = 10'h000;
        for (int k = 0; k < 8; k++) begin
            step();
            rd(16'hFFF2, 16'h0000, "sdata_glitch");
        end
        SW = 10'h2A5;
        for (int k = 1; k <= 6; k++) begin
            step();
            rd(16'hFFF2, (k == 6) ? 16'h02A5 : 16'h0000, "sdata_hold");
        end

        KEY = 4'b1110;
        steps(6);
        rd(16'hFFF4, 16'h0005, "kstat_two");
        wr(16'hFFF4, 16'h0001);
        rd(16'hFFF4, 16'h0004, "kstat_w1c");
        KEY = 4'hF;
        steps(6);
        KEY = 4'b1011;
        steps(5);
        wr(16'hFFF4, 16'h0004);
        rd(16'hFFF4, 16'h0004, "kstat_set_wins");
        rd(16'hFFF0, 16'h0004, "kdata_set_wins");

        KEY = 4'hF;
        steps(6);
        wr(16'hFFF8, 16'h1234);
        KEY = 4'b1101;
        steps(5);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("rst_mid_hex", HEX_VAL, 16'h0000);
        rd(16'hFFF4, 16'h0000, "rst_mid_kstat");
        rd(16'hFFF0, 16'h0000, "rst_mid_kdata");
        for (int k = 1; k <= 6; k++) begin
            step();
            rd(16'hFFF0, (k == 6) ? 16'h0002 : 16'h0000, "kdata_after_rst");
        end

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) KEY[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) SW[$urandom_range(0, 9)] ^= 1'b1;
            if ($urandom_range(0, 3) != 0) ADDR = 16'hFFF0 | 16'($urandom_range(0, 15));
            else ADDR = 16'($urandom);
            DIN   = 16'($urandom);
            WE    = ($urandom_range(0, 3) == 0);
            RESET = ($urandom_range(0, 150) == 0);
            step();
        end
        RESET = 1'b0;
        WE = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
